// File: rtl/ccp_double_wr_port_queue.sv
// Two-write-port, one-read-port show-ahead FIFO for recording expected transactions.
// An empty queue forwards the first same-cycle push straight to data_out.
module ccp_double_wr_port_queue #(
  parameter int QUEUE_DEPTH = 24,
  parameter int MEM_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_1,
  input  logic [MEM_W-1:0] data_in_1,
  input  logic             push_2,
  input  logic [MEM_W-1:0] data_in_2,
  input  logic             pop,
  output logic [MEM_W-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             sample_bit
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

  logic [MEM_W-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty, pop_eff, pop_stored, pop_bypass;
  logic             acc_1, acc_2;
  logic [CNT_W:0]   space;
  logic [1:0]       n_wr;
  logic [MEM_W-1:0] wr_data_a;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake: push_1/push_2 are fire-and-forget write requests (no ready);
  // each is taken in port order only while a slot is free, otherwise dropped.
  // pop consumes the head only when data is presented (stored or bypassed).
  always_comb begin
    not_empty  = (count_q != '0);
    pop_eff    = pop & (not_empty | push_1 | push_2);
    pop_stored = pop_eff & not_empty;
    pop_bypass = pop_eff & ~not_empty;
    space      = {1'b0, DEPTH_C} - {1'b0, count_q} + {{CNT_W{1'b0}}, pop_stored};
    acc_1      = push_1 & (space != '0);
    acc_2      = push_2 & (space > {{CNT_W{1'b0}}, acc_1});
    // A bypass pop swallows the first accepted push, so fewer items get stored.
    n_wr       = {1'b0, acc_1} + {1'b0, acc_2} - {1'b0, pop_bypass};
    wr_data_a  = (acc_1 & ~pop_bypass) ? data_in_1 : data_in_2;
    wr_ptr_nxt = ptr_inc(wr_ptr_q);
    case (n_wr)
      2'd0:    wr_ptr_d = wr_ptr_q;
      2'd1:    wr_ptr_d = wr_ptr_nxt;
      default: wr_ptr_d = ptr_inc(wr_ptr_nxt);
    endcase
    rd_ptr_d = pop_stored ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(acc_1) + CNT_W'(acc_2) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (n_wr != 2'd0) mem_q[wr_ptr_q]   <= wr_data_a;
    if (n_wr == 2'd2) mem_q[wr_ptr_nxt] <= data_in_2;
  end

  always_comb begin
    if (not_empty)   data_out = mem_q[rd_ptr_q];
    else if (push_1) data_out = data_in_1;
    else if (push_2) data_out = data_in_2;
    else             data_out = '0;
  end

  assign full       = (count_q == DEPTH_C);
  assign empty      = ~not_empty;
  assign sample_bit = data_out[0];

endmodule

// File: tb/tb_ccp_double_wr_port_queue.sv
// Directed bench for ccp_double_wr_port_queue: queue model plus hand-computed checks.
module tb_ccp_double_wr_port_queue;

  localparam int DEPTH = 24;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         push_1 = 1'b0;
  logic [W-1:0] data_in_1 = '0;
  logic         push_2 = 1'b0;
  logic [W-1:0] data_in_2 = '0;
  logic         pop = 1'b0;
  logic [W-1:0] data_out;
  logic         full, empty, sample_bit;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  ccp_double_wr_port_queue #(.QUEUE_DEPTH(DEPTH), .MEM_W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .push_1(push_1), .data_in_1(data_in_1),
    .push_2(push_2), .data_in_2(data_in_2),
    .pop(pop), .data_out(data_out),
    .full(full), .empty(empty), .sample_bit(sample_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check presented outputs against the queue model, clock, idle.
  task automatic step(input string tag, input logic p1, input logic [W-1:0] d1,
                      input logic p2, input logic [W-1:0] d2, input logic pp);
    int cnt;
    int space;
    bit pe, a1, a2;
    logic [W-1:0] exp_do;
    push_1 = p1; data_in_1 = d1; push_2 = p2; data_in_2 = d2; pop = pp;
    #1;
    cnt = exp_q.size();
    exp_do = (cnt > 0) ? exp_q[0] : (p1 ? d1 : (p2 ? d2 : '0));
    chk({tag, "_dout"}, data_out, exp_do);
    chk({tag, "_sbit"}, sample_bit, exp_do[0]);
    chk({tag, "_empty"}, empty, cnt == 0);
    chk({tag, "_full"}, full, cnt == DEPTH);
    pe    = pp && (cnt > 0 || p1 || p2);
    space = DEPTH - cnt + ((pe && cnt > 0) ? 1 : 0);
    a1    = p1 && (space >= 1);
    a2    = p2 && (space >= (a1 ? 2 : 1));
    if (a1) exp_q.push_back(d1);
    if (a2) exp_q.push_back(d2);
    if (pe) void'(exp_q.pop_front());
    @(posedge clk); #1;
    push_1 = 1'b0; push_2 = 1'b0; pop = 1'b0; data_in_1 = '0; data_in_2 = '0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_sbit", sample_bit, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;

    // Single-port pushes then pops
    step("t1_push", 1, 8'h11, 0, 0, 0);
    chk("t1_head_a", data_out, 8'h11);
    chk("t1_nempty", empty, 0);
    step("t1_push", 1, 8'h22, 0, 0, 0);
    step("t1_push", 1, 8'h33, 0, 0, 0);
    chk("t1_head_b", data_out, 8'h11);
    step("t1_pop", 0, 0, 0, 0, 1);
    chk("t1_pop1", data_out, 8'h22);
    step("t1_pop", 0, 0, 0, 0, 1);
    chk("t1_pop2", data_out, 8'h33);
    step("t1_pop", 0, 0, 0, 0, 1);
    chk("t1_empty", empty, 1);
    chk("t1_dout0", data_out, 0);

    // Dual push on empty
    step("t2_dual", 1, 8'hA1, 1, 8'hB2, 0);
    chk("t2_count", dut.count_q, 2);
    chk("t2_head", data_out, 8'hA1);
    step("t2_pop", 0, 0, 0, 0, 1);
    chk("t2_second", data_out, 8'hB2);
    step("t2_pop", 0, 0, 0, 0, 1);
    chk("t2_empty", empty, 1);

    // Bypass cases
    step("t3_byp1", 1, 8'h5C, 0, 0, 1);
    chk("t3_count", dut.count_q, 0);
    chk("t3_empty", empty, 1);
    step("t3_byp2", 0, 0, 1, 8'h37, 1);
    chk("t3_empty2", empty, 1);
    step("t3_bypdual", 1, 8'h61, 1, 8'h62, 1);
    chk("t3_count1", dut.count_q, 1);
    chk("t3_left", data_out, 8'h62);
    step("t3_pop", 0, 0, 0, 0, 1);
    step("t3_underflow", 0, 0, 0, 0, 1);
    chk("t3_uf_count", dut.count_q, 0);
    chk("t3_uf_dout", data_out, 0);

    // Full, drop at full, push+pop at full
    for (int i = 0; i < DEPTH; i++) step("t4_fill", 1, W'(i + 1), 0, 0, 0);
    chk("t4_full", full, 1);
    chk("t4_count", dut.count_q, DEPTH);
    step("t4_drop", 1, 8'hFF, 0, 0, 0);
    chk("t4_drop_full", full, 1);
    chk("t4_drop_head", data_out, 8'h01);
    step("t4_pushpop", 1, 8'hEE, 0, 0, 1);
    chk("t4_pp_full", full, 1);
    chk("t4_pp_head", data_out, 8'h02);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t4_last_ee", data_out, 8'hEE);
      step("t4_drain", 0, 0, 0, 0, 1);
    end
    chk("t4_empty", empty, 1);

    // Dual push with a single free slot: only port 1 is taken
    for (int i = 0; i < DEPTH - 1; i++) step("t4b_fill", 1, W'(8'h80 + i), 0, 0, 0);
    step("t4b_dual", 1, 8'hC1, 1, 8'hC2, 0);
    chk("t4b_count", dut.count_q, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t4b_last_c1", data_out, 8'hC1);
      step("t4b_drain", 0, 0, 0, 0, 1);
    end
    chk("t4b_empty", empty, 1);

    // Alternating traffic across pointer wrap
    for (int i = 0; i < 3; i++) step("t5_pre", 1, W'(8'h30 + i), 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 4)      step("t5_both", 1, W'(8'h40 + i), 0, 0, 1);
      else if (i % 2 == 0) step("t5_push", 1, W'(8'h40 + i), 0, 0, 0);
      else                 step("t5_pop", 0, 0, 0, 0, 1);
    end
    while (exp_q.size() > 0) step("t5_drain", 0, 0, 0, 0, 1);
    chk("t5_empty", empty, 1);

    // Asynchronous reset with entries stored
    for (int i = 0; i < 5; i++) step("t6_fill", 1, W'(8'hD0 + i), 0, 0, 0);
    chk("t6_pre_count", dut.count_q, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_empty", empty, 1);
    chk("t6_async_full", full, 0);
    chk("t6_async_dout", data_out, 0);
    exp_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    #1;
    chk("t6_rel_empty", empty, 1);
    chk("t6_rel_dout", data_out, 0);
    step("t6_push", 1, 8'h42, 0, 0, 0);
    chk("t6_fresh", data_out, 8'h42);
    step("t6_pop", 0, 0, 0, 0, 1);
    chk("t6_end_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
